gshare_predictor: RTL and testbench
===================================

Name: gshare_predictor

Overview:
- Next-generation parametrised direction predictor for the fetch stage, indexed by PC XOR global history (gshare).
- Provides configurable counter width, a global history register (GHR) and a sequential table-clear engine in place of a single-cycle bulk reset.
- Prediction is combinational to fetch. The resolving stage (EX) trains the table with the GHR snapshot captured at lookup.

Parameters:
- ENTRY_NUM, 1024, table entries; power of two, ≥ 4.
- INDEX_BITS, $clog2(ENTRY_NUM), table index width.
- HIST_BITS, 8, GHR width; legal range 1..INDEX_BITS.
- CTR_BITS, 2, saturating counter width; legal range 2..4.
- TAG_BITS, 8, partial tag width; used only with BHT_TAG_EN.

Ports:
- clk, input, 1, clock.
- reset_n, input, 1, synchronous active-low reset.
- ready, output, 1, table clear complete; lookups valid.
- lookup_pc, input, 32, fetch PC.
- predict_taken, output, 1, predicted direction.
- predict_hit, output, 1, entry valid (and tag match when BHT_TAG_EN is defined).
- lookup_ghr, output, HIST_BITS, current GHR; pipelined alongside the branch.
- update_en, input, 1, branch resolved this cycle.
- update_pc, input, 32, resolved branch PC.
- update_ghr, input, HIST_BITS, GHR snapshot carried from lookup.
- actual_taken, input, 1, resolved direction.

Behaviour:
- Index: idx = PC[INDEX_BITS+1:2] XOR {zero-extend to INDEX_BITS}(ghr).
  - Lookup uses the live GHR.
  - Update uses update_ghr.
- Counter constants:
  - WNT = 2^(CTR_BITS-1)-1, WT = 2^(CTR_BITS-1), MAX = 2^CTR_BITS-1.
  - Prediction = counter MSB.
- FSM state CLEAR:
  - Entered on any cycle with reset_n=0. Reset also sets clr_ptr=0, GHR=0, ready=0.
  - Each cycle after reset_n goes high, writes entry[clr_ptr] = {valid=0, ctr=WNT}, then clr_ptr++.
  - Moves to RUN on the cycle the entry ENTRY_NUM-1 write occurs. ready=1 from the next cycle, i.e. exactly ENTRY_NUM cycles after reset release.
  - reset_n low mid-sweep restarts the sweep at 0.
  - During CLEAR: predict_taken=0, predict_hit=0, update_en ignored, GHR not shifted.
- FSM state RUN:
  - predict_hit = valid (&& tag match). predict_taken = hit ? ctr[MSB] : 0.
  - On update_en with a miss: allocate the entry with valid=1, ctr = actual_taken ? WT : WNT. Write the tag when tags are compiled in.
  - On update_en with a hit: saturating ±1; stays at 0 or MAX when saturated.
  - On every update_en: GHR <= {GHR[HIST_BITS-2:0], actual_taken}. This is non-speculative. When HIST_BITS=1, GHR <= actual_taken.
- Same-cycle lookup and update:
  - Lookup sees pre-update table contents; there is no bypass.
  - lookup_ghr shows the pre-shift GHR.
- Outputs are combinational from table/GHR. Reset values: ready=0, predict_taken=0, predict_hit=0, lookup_ghr=0.

Optional Feature:
- Macro name: BHT_TAG_EN.
- Defined:
  - Each entry stores tag = PC[INDEX_BITS+TAG_BITS+1 : INDEX_BITS+2].
  - Hit requires valid && tag equal.
  - An update that mismatches the stored tag reallocates the entry: new tag, and ctr = WT or WNT from actual_taken.
  - The sweep clears tags to 0.
- Undefined:
  - No tag storage; hit = valid.
  - TAG_BITS is unused.

Decomposition:
- Package bp_pkg:
  - bp_state_e {CLEAR, RUN}.
  - Functions ctr_wnt/ctr_wt/ctr_max(CTR_BITS).
  - Parametrised entry struct (valid, optional tag, ctr).
- Sub-module sat_counter_next:
  - Combinational next-value of a CTR_BITS saturating counter given current value, actual_taken and alloc flag.
  - Instantiated once on the update path.

Test Plan:
1. Clear sweep, ENTRY_NUM=16: hold reset_n=0 2 cycles, release → ready=0 for 16 cycles, 1 on 17th. Lookup at any PC → predict_hit=0, predict_taken=0. update_en during the sweep leaves the table unchanged.
2. Allocation and saturation, CTR_BITS=2, HIST_BITS=1 with the GHR held at 0 (update_ghr=0):
   - First update of PC 0x40 taken → predict_taken=1.
   - A second taken update saturates ctr at 3.
   - Two not-taken updates → ctr 1, predict_taken=0.
3. History aliasing, ENTRY_NUM=16, HIST_BITS=4:
   - Drive taken,taken → GHR=0b0011.
   - PC 0x0C (idx 3) now indexes entry 0. An update at PC 0x0C with update_ghr=0b0011 trains entry 0.
   - A lookup of PC 0x00 at GHR=0 then hits.
4. Same-cycle lookup/update, same index, entry ctr=1, actual_taken=1 → lookup that cycle returns predict_taken=0, next cycle returns 1.
5. Mid-sweep reset: assert reset_n=0 at clr_ptr=7 → sweep restarts at 0, ready rises ENTRY_NUM cycles after the release.
6. BHT_TAG_EN defined, ENTRY_NUM=16, HIST_BITS=1, GHR held at 0:
   - Train PC 0x40 taken.
   - Lookup PC 0x80 (same index, different tag) → predict_hit=0.
   - Update PC 0x80 not-taken → reallocates with ctr=WNT; PC 0x40 now misses.

Source files
------------

// File: rtl/bp_pkg.sv
// bp_pkg: shared predictor-control state type and saturating counter constants
package bp_pkg;
  typedef enum logic {CLEAR, RUN} bp_state_e;
  function automatic logic [3:0] ctr_wnt(input int ctr_bits);
    return 4'((1 << (ctr_bits - 1)) - 1);
  endfunction
  function automatic logic [3:0] ctr_wt(input int ctr_bits);
    return 4'(1 << (ctr_bits - 1));
  endfunction
  function automatic logic [3:0] ctr_max(input int ctr_bits);
    return 4'((1 << ctr_bits) - 1);
  endfunction
endpackage

// File: rtl/sat_counter_next.sv
// sat_counter_next: next value of a saturating direction counter, or its fresh allocation value
module sat_counter_next import bp_pkg::*; #(
  parameter int CTR_BITS = 2
) (
  input  logic [CTR_BITS-1:0] i_ctr,
  input  logic                i_taken,
  input  logic                i_alloc,
  output logic [CTR_BITS-1:0] o_ctr
);
  localparam logic [CTR_BITS-1:0] WNT = CTR_BITS'(ctr_wnt(CTR_BITS));
  localparam logic [CTR_BITS-1:0] WT  = CTR_BITS'(ctr_wt(CTR_BITS));
  localparam logic [CTR_BITS-1:0] MAX = CTR_BITS'(ctr_max(CTR_BITS));
  // allocation seeds weakly toward the outcome; otherwise step one and hold at the rails
  always_comb o_ctr = i_alloc ? (i_taken ? WT : WNT) :
                      i_taken ? (i_ctr == MAX ? i_ctr : i_ctr + 1'b1) :
                                (i_ctr == '0 ? i_ctr : i_ctr - 1'b1);
endmodule

// File: rtl/gshare_predictor.sv
// gshare_predictor: PC^GHR indexed direction predictor with sequential table clear; BHT_TAG_EN adds partial tags
module gshare_predictor import bp_pkg::*; #(
  parameter int ENTRY_NUM  = 1024,
  parameter int INDEX_BITS = $clog2(ENTRY_NUM),
  parameter int HIST_BITS  = 8,
  parameter int CTR_BITS   = 2,
  parameter int TAG_BITS   = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  output logic                 ready,
  input  logic [31:0]          lookup_pc,
  output logic                 predict_taken,
  output logic                 predict_hit,
  output logic [HIST_BITS-1:0] lookup_ghr,
  input  logic                 update_en,
  input  logic [31:0]          update_pc,
  input  logic [HIST_BITS-1:0] update_ghr,
  input  logic                 actual_taken
);
  typedef struct packed {
    logic                valid;
`ifdef BHT_TAG_EN
    logic [TAG_BITS-1:0] tag;
`endif
    logic [CTR_BITS-1:0] ctr;
  } entry_t;
  localparam logic [CTR_BITS-1:0]   WNT  = CTR_BITS'(ctr_wnt(CTR_BITS));
  localparam logic [INDEX_BITS-1:0] LAST = INDEX_BITS'(ENTRY_NUM - 1);
  bp_state_e             r_state, w_state_next;
  logic [INDEX_BITS-1:0] r_clr_ptr, w_lidx, w_uidx, w_widx;
  logic [HIST_BITS-1:0]  r_ghr;
  entry_t                r_table [ENTRY_NUM];
  entry_t                w_lent, w_uent, w_wdata;
  logic                  w_run, w_lhit, w_uhit, w_we;
  logic [CTR_BITS-1:0]   w_ctr_next;
  assign w_run  = r_state == RUN;
  assign w_lidx = lookup_pc[INDEX_BITS+1:2] ^ INDEX_BITS'(r_ghr);
  assign w_uidx = update_pc[INDEX_BITS+1:2] ^ INDEX_BITS'(update_ghr);
  assign w_lent = r_table[w_lidx];
  assign w_uent = r_table[w_uidx];
`ifdef BHT_TAG_EN
  logic [TAG_BITS-1:0] w_ltag, w_utag;
  logic                w_unused;
  assign w_ltag   = lookup_pc[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2];
  assign w_utag   = update_pc[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2];
  assign w_lhit   = w_lent.valid && w_lent.tag == w_ltag;
  assign w_uhit   = w_uent.valid && w_uent.tag == w_utag;
  assign w_unused = ^{lookup_pc[31:INDEX_BITS+TAG_BITS+2], lookup_pc[1:0],
                      update_pc[31:INDEX_BITS+TAG_BITS+2], update_pc[1:0], w_lent.ctr[CTR_BITS-2:0]};
`else
  logic [TAG_BITS-1:0] w_unused_tag;
  logic                w_unused;
  assign w_unused_tag = '0;
  assign w_lhit       = w_lent.valid;
  assign w_uhit       = w_uent.valid;
  assign w_unused     = ^{lookup_pc[31:INDEX_BITS+2], lookup_pc[1:0],
                          update_pc[31:INDEX_BITS+2], update_pc[1:0], w_lent.ctr[CTR_BITS-2:0]};
`endif
  sat_counter_next #(.CTR_BITS(CTR_BITS)) u_ctr (
    .i_ctr   (w_uent.ctr),
    .i_taken (actual_taken),
    .i_alloc (!w_uhit),
    .o_ctr   (w_ctr_next)
  );
  // one shared write port: the clear sweep owns it in CLEAR, training owns it in RUN
  always_comb begin
    w_we          = reset_n && (w_run ? update_en : 1'b1);
    w_widx        = w_run ? w_uidx : r_clr_ptr;
    w_wdata       = '0;
    w_wdata.valid = w_run;
    w_wdata.ctr   = w_run ? w_ctr_next : WNT;
`ifdef BHT_TAG_EN
    w_wdata.tag   = w_run ? w_utag : '0;
`endif
  end
  // leave CLEAR on the cycle the last entry is written
  always_comb w_state_next = (!w_run && r_clr_ptr == LAST) ? RUN : r_state;
  // state register; reset restarts the sweep
  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= CLEAR;
    else          r_state <= w_state_next;
  end
  // sweep pointer and non-speculative global history
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_clr_ptr <= '0;
      r_ghr     <= '0;
    end else begin
      if (!w_run) r_clr_ptr <= r_clr_ptr + 1'b1;
      if (w_run && update_en) r_ghr <= HIST_BITS'({r_ghr, actual_taken});
    end
  end
  // table storage has no reset; the sweep initialises it
  always_ff @(posedge clk) begin
    if (w_we) r_table[w_widx] <= w_wdata;
  end
  assign ready         = w_run;
  assign predict_hit   = w_run && w_lhit;
  assign predict_taken = predict_hit && w_lent.ctr[CTR_BITS-1];
  assign lookup_ghr    = r_ghr;
endmodule

// File: tb/tb_gshare_predictor.sv
// tb_gshare_predictor: directed checks of clear sweep, training, history indexing and tags
module tb_gshare_predictor;
  logic        clk = 0, reset_n = 0;
  int          n_tests = 0, n_fail = 0;
  logic [31:0] l1_pc = 0, u1_pc = 0, l4_pc = 0, u4_pc = 0;
  logic        u1_en = 0, u1_ghr = 0, u1_t = 0, u4_en = 0, u4_t = 0;
  logic [3:0]  u4_ghr = 0;
  logic        rdy1, pt1, ph1, lg1, rdy4, pt4, ph4;
  logic [3:0]  lg4;
  always #5 clk = ~clk;
  gshare_predictor #(.ENTRY_NUM(16), .HIST_BITS(1), .CTR_BITS(2), .TAG_BITS(8)) u_h1 (
    .clk(clk), .reset_n(reset_n), .ready(rdy1), .lookup_pc(l1_pc), .predict_taken(pt1),
    .predict_hit(ph1), .lookup_ghr(lg1), .update_en(u1_en), .update_pc(u1_pc),
    .update_ghr(u1_ghr), .actual_taken(u1_t));
  gshare_predictor #(.ENTRY_NUM(16), .HIST_BITS(4), .CTR_BITS(2), .TAG_BITS(8)) u_h4 (
    .clk(clk), .reset_n(reset_n), .ready(rdy4), .lookup_pc(l4_pc), .predict_taken(pt4),
    .predict_hit(ph4), .lookup_ghr(lg4), .update_en(u4_en), .update_pc(u4_pc),
    .update_ghr(u4_ghr), .actual_taken(u4_t));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic upd1(input logic [31:0] pc, input logic t);
    u1_en = 1; u1_pc = pc; u1_ghr = 0; u1_t = t;
    step();
    u1_en = 0;
  endtask
  task automatic upd4(input logic [31:0] pc, input logic [3:0] g, input logic t);
    u4_en = 1; u4_pc = pc; u4_ghr = g; u4_t = t;
    step();
    u4_en = 0;
  endtask
  task automatic wait_ready(input string tag);
    int n = 0;
    while (!rdy4 && n < 40) begin
      step();
      n++;
    end
    check(tag, n, 16);
    check({tag, "_h1"}, rdy1, 1);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    reset_n = 0;
    step(); step();
    check("rst_ready", rdy1, 0);
    check("rst_hit", ph1, 0);
    check("rst_taken", pt1, 0);
    check("rst_ghr", lg1, 0);
    check("rst_ready4", rdy4, 0);
    reset_n = 1;
    u1_en = 1; u1_pc = 32'h40; u1_t = 1; l1_pc = 32'h40;
    #1;
    check("sweep_hit", ph1, 0);
    wait_ready("sweep_latency");
    u1_en = 0;
    #1;
    check("sweep_upd_ignored_hit", ph1, 0);
    check("sweep_upd_ignored_ghr", lg1, 0);
    upd1(32'h40, 1);
    l1_pc = 32'h44; #1;
    check("alloc_hit", ph1, 1);
    check("alloc_taken", pt1, 1);
    check("alloc_ghr", lg1, 1);
    l1_pc = 32'h40; #1;
    check("alloc_other_idx_miss", ph1, 0);
    l1_pc = 32'h44;
    upd1(32'h40, 1); #1;
    check("ctr3_taken", pt1, 1);
    upd1(32'h40, 1); #1;
    check("sat_high_taken", pt1, 1);
    upd1(32'h40, 0);
    l1_pc = 32'h40; #1;
    check("ctr2_taken", pt1, 1);
    check("ghr_after_nt", lg1, 0);
    upd1(32'h40, 0); #1;
    check("ctr1_taken", pt1, 0);
    check("ctr1_hit", ph1, 1);
    upd1(32'h40, 0);
    upd1(32'h40, 0);
    upd1(32'h40, 1);
    l1_pc = 32'h44; #1;
    check("sat_low_ctr1", pt1, 0);
    u1_en = 1; u1_pc = 32'h40; u1_ghr = 0; u1_t = 1; #1;
    check("same_cycle_old_taken", pt1, 0);
    check("same_cycle_old_hit", ph1, 1);
    step();
    u1_en = 0; #1;
    check("same_cycle_next_taken", pt1, 1);
    upd4(32'h20, 4'h0, 1);
    check("hist_ghr1", lg4, 4'h1);
    u4_en = 1; u4_pc = 32'h20; u4_ghr = 4'h1; u4_t = 1; #1;
    check("hist_pre_shift", lg4, 4'h1);
    step();
    u4_en = 0;
    check("hist_ghr3", lg4, 4'h3);
    l4_pc = 32'h0C; #1;
    check("hist_0c_miss", ph4, 0);
    upd4(32'h0C, 4'h3, 1);
    check("hist_ghr7", lg4, 4'h7);
    for (int i = 0; i < 4; i++) upd4(32'h20, 4'h0, 0);
    check("hist_ghr0", lg4, 4'h0);
    l4_pc = 32'h00; #1;
    check("alias_hit", ph4, 1);
    check("alias_taken", pt4, 1);
    l4_pc = 32'h0C; #1;
    check("alias_0c_miss", ph4, 0);
    reset_n = 0;
    step();
    reset_n = 1;
    for (int i = 0; i < 7; i++) step();
    check("midsweep_not_ready", rdy4, 0);
    reset_n = 0;
    step();
    reset_n = 1;
    wait_ready("midsweep_latency");
    l4_pc = 32'h00; #1;
    check("midsweep_cleared", ph4, 0);
    check("midsweep_ghr", lg1, 0);
    upd1(32'h40, 1);
`ifdef BHT_TAG_EN
    l1_pc = 32'h84; #1;
    check("tag_mismatch_miss", ph1, 0);
    l1_pc = 32'h44; #1;
    check("tag_match_hit", ph1, 1);
    check("tag_match_taken", pt1, 1);
    upd1(32'h80, 0);
    l1_pc = 32'h40; #1;
    check("tag_old_evicted", ph1, 0);
    l1_pc = 32'h80; #1;
    check("tag_realloc_hit", ph1, 1);
    check("tag_realloc_wnt", pt1, 0);
`else
    l1_pc = 32'h84; #1;
    check("notag_alias_hit", ph1, 1);
    check("notag_alias_taken", pt1, 1);
    upd1(32'h80, 0);
    l1_pc = 32'h40; #1;
    check("notag_shared_hit", ph1, 1);
    check("notag_shared_dec", pt1, 0);
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
